reg_file_sb: RTL and testbench
==============================

// Module: reg_file_sb
// PURPOSE
//  Parametrised next-generation CPU register file: 2 write ports with byte enables, 2 read ports.
//  Reads are synchronous (1-cycle latency) and see same-cycle writes through an optional bypass.
//  An integrated scoreboard tracks one busy bit per register for hazard detection.
//  Sits between the decode stage (reads, scoreboard set) and the writeback stage (writes).
// PARAMETERS
//  XLEN      32  register width in bits; must be a multiple of 8
//  NREGS     32  number of registers; must be a power of 2, >= 2
//  ZERO_REG  1   1: R0 reads 0, ignores writes and is never busy; 0: R0 is an ordinary register
//  BYPASS    1   1: a read sees same-cycle write data; 0: a read sees the pre-write contents
//  (localparams: AW = $clog2(NREGS), BW = XLEN/8)
// PORTS
//  clk          in   1     clock; all state updates on posedge
//  reset        in   1     synchronous, active-high reset
//  wr0_en       in   1     write port 0 enable
//  wr0_addr     in   AW    write port 0 register index
//  wr0_be       in   BW    write port 0 byte enables; bit i enables data[8i+7:8i]
//  wr0_data     in   XLEN  write port 0 data
//  wr1_en       in   1     write port 1 enable
//  wr1_addr     in   AW    write port 1 register index
//  wr1_be       in   BW    write port 1 byte enables
//  wr1_data     in   XLEN  write port 1 data
//  sb_set_en    in   1     mark register sb_set_addr busy (destination issued)
//  sb_set_addr  in   AW    register index to mark busy
//  rd_en        in   1     capture a new read on both read ports
//  rd_addr_a    in   AW    read port A index
//  rd_addr_b    in   AW    read port B index
//  rd_data_a    out  XLEN  read port A data, registered
//  rd_data_b    out  XLEN  read port B data, registered
//  rd_busy_a    out  1     busy bit of rd_addr_a, registered with rd_data_a
//  rd_busy_b    out  1     busy bit of rd_addr_b, registered with rd_data_b
//  rd_valid     out  1     rd_en delayed by one cycle
//  wr_done      out  1     1-cycle pulse: an effective write occurred in the previous cycle
// BEHAVIOUR
//  - Reset: all registers, busy bits, rd_data_*, rd_busy_*, rd_valid and wr_done go to 0.
//    Writes, sb_set and reads presented in a reset cycle are dropped.
//  - Effective write: wrN_en=1, wrN_be!=0, and (ZERO_REG=0 or wrN_addr!=0).
//    Only bytes enabled in wrN_be are updated; the other bytes keep their value.
//  - Two writes to the same address in one cycle: the merge is per byte.
//    Port 1 wins on bytes enabled by both ports; bytes enabled by only one port take that port's data.
//  - Scoreboard:
//    - busy[r] clears on any effective write to r.
//    - sb_set_en sets busy[sb_set_addr]. If set and clear hit the same register in one cycle, set wins.
//    - With ZERO_REG=1, sb_set_en to R0 is ignored.
//  - Read (rd_en=1 in cycle T): rd_data_*, rd_busy_* and rd_valid update at the T+1 edge.
//    - With rd_en=0, rd_data_* and rd_busy_* hold their values and rd_valid=0.
//    - BYPASS=1: rd_data is the register's post-write value of cycle T (byte-merged).
//      rd_busy is the busy bit's next-state value, so clear and set are both applied.
//    - BYPASS=0: rd_data and rd_busy are the values as they stood at the start of cycle T.
//    - With ZERO_REG=1, reading R0 always returns data 0 and busy 0.
//  - wr_done=1 in cycle T+1 if at least one port performed an effective write in cycle T; otherwise 0.
//  - All ports are independent; any combination may be active in the same cycle.
// TESTING
//  1 reset; read R1..R31 -> all data 0, busy 0; rd_valid=1 only in the cycle after each rd_en.
//  2 wr0 R5=0xDEADBEEF be=F; next cycle wr0 R5 data=0x00001122 be=3 -> R5 reads 0xDEAD1122; wr_done pulses each time.
//  3 same cycle: wr0 R7=0x11111111 be=F, wr1 R7=0x22222222 be=C -> R7 = 0x22221111.
//  4 BYPASS=1: wr0 R3=0xA5A5A5A5 with rd_addr_a=3 in the same cycle -> rd_data_a=0xA5A5A5A5 next cycle.
//    BYPASS=0: same stimulus -> old R3 value.
//  5 sb_set R9; read R9 -> busy 1; then write R9 and sb_set R9 in the same cycle -> busy stays 1;
//    then a lone write to R9 -> busy 0.
//  6 ZERO_REG=1: wr0 R0=0xFFFFFFFF and sb_set R0 -> R0 reads 0, busy 0, wr_done 0.
//    Separately, assert reset mid-write -> write discarded and all outputs 0.

Source files
------------

// File: rtl/reg_file_sb.sv
// reg_file_sb: two-write/two-read register file with byte enables, optional write bypass
// on reads, and a per-register busy-bit scoreboard for hazard detection.
module reg_file_sb #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr0_en,
    input  logic [$clog2(NREGS)-1:0] wr0_addr,
    input  logic [XLEN/8-1:0]        wr0_be,
    input  logic [XLEN-1:0]          wr0_data,
    input  logic                     wr1_en,
    input  logic [$clog2(NREGS)-1:0] wr1_addr,
    input  logic [XLEN/8-1:0]        wr1_be,
    input  logic [XLEN-1:0]          wr1_data,
    input  logic                     sb_set_en,
    input  logic [$clog2(NREGS)-1:0] sb_set_addr,
    input  logic                     rd_en,
    input  logic [$clog2(NREGS)-1:0] rd_addr_a,
    input  logic [$clog2(NREGS)-1:0] rd_addr_b,
    output logic [XLEN-1:0]          rd_data_a,
    output logic [XLEN-1:0]          rd_data_b,
    output logic                     rd_busy_a,
    output logic                     rd_busy_b,
    output logic                     rd_valid,
    output logic                     wr_done
);
    localparam int BW = XLEN / 8;

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic [NREGS-1:0] busy_q, busy_d;
    logic [XLEN-1:0]  rd_data_a_q, rd_data_b_q, rd_data_a_d, rd_data_b_d;
    logic             rd_busy_a_q, rd_busy_b_q, rd_busy_a_d, rd_busy_b_d;
    logic             rd_valid_q, wr_done_q;
    logic             wr0_eff, wr1_eff, sb_eff, zero_a, zero_b;

    assign wr0_eff = wr0_en && (wr0_be != '0) && (ZERO_REG == 0 || wr0_addr != '0);
    assign wr1_eff = wr1_en && (wr1_be != '0) && (ZERO_REG == 0 || wr1_addr != '0);
    assign sb_eff  = sb_set_en && (ZERO_REG == 0 || sb_set_addr != '0);
    assign zero_a  = ZERO_REG != 0 && rd_addr_a == '0;
    assign zero_b  = ZERO_REG != 0 && rd_addr_b == '0;

    // Port 1 is applied after port 0 so it wins on bytes both ports enable.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int i = 0; i < BW; i++) begin
            if (wr0_eff && wr0_be[i]) regs_d[wr0_addr][8*i +: 8] = wr0_data[8*i +: 8];
            if (wr1_eff && wr1_be[i]) regs_d[wr1_addr][8*i +: 8] = wr1_data[8*i +: 8];
        end
        if (wr0_eff) busy_d[wr0_addr] = 1'b0;
        if (wr1_eff) busy_d[wr1_addr] = 1'b0;
        if (sb_eff) busy_d[sb_set_addr] = 1'b1;
    end

    assign rd_data_a_d = zero_a ? '0 : BYPASS != 0 ? regs_d[rd_addr_a] : regs_q[rd_addr_a];
    assign rd_data_b_d = zero_b ? '0 : BYPASS != 0 ? regs_d[rd_addr_b] : regs_q[rd_addr_b];
    assign rd_busy_a_d = !zero_a && (BYPASS != 0 ? busy_d[rd_addr_a] : busy_q[rd_addr_a]);
    assign rd_busy_b_d = !zero_b && (BYPASS != 0 ? busy_d[rd_addr_b] : busy_q[rd_addr_b]);

    always_ff @(posedge clk) begin
        if (reset) begin
            regs_q      <= '{default: '0};
            busy_q      <= '0;
            rd_data_a_q <= '0;
            rd_data_b_q <= '0;
            rd_busy_a_q <= 1'b0;
            rd_busy_b_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            wr_done_q   <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            busy_q     <= busy_d;
            rd_valid_q <= rd_en;
            wr_done_q  <= wr0_eff || wr1_eff;
            if (rd_en) begin
                rd_data_a_q <= rd_data_a_d;
                rd_data_b_q <= rd_data_b_d;
                rd_busy_a_q <= rd_busy_a_d;
                rd_busy_b_q <= rd_busy_b_d;
            end
        end
    end

    assign rd_data_a = rd_data_a_q;
    assign rd_data_b = rd_data_b_q;
    assign rd_busy_a = rd_busy_a_q;
    assign rd_busy_b = rd_busy_b_q;
    assign rd_valid  = rd_valid_q;
    assign wr_done   = wr_done_q;
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed + random stimulus on two configurations
// (k=0: ZERO_REG=1/BYPASS=1, k=1: ZERO_REG=0/BYPASS=0) against an array-based reference model.
module tb_reg_file_sb;
    logic        clk = 1'b0;
    logic        reset, wr0_en, wr1_en, sb_set_en, rd_en;
    logic [4:0]  wr0_addr, wr1_addr, sb_set_addr, rd_addr_a, rd_addr_b;
    logic [3:0]  wr0_be, wr1_be;
    logic [31:0] wr0_data, wr1_data;
    logic [31:0] o_da [2];
    logic [31:0] o_db [2];
    logic        o_ba [2];
    logic        o_bb [2];
    logic        o_v  [2];
    logic        o_wd [2];

    logic [31:0] mem  [2][32];
    logic [31:0] busy [2];
    logic [31:0] e_da [2];
    logic [31:0] e_db [2];
    logic        e_ba [2];
    logic        e_bb [2];
    logic        e_v  [2];
    logic        e_wd [2];
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    reg_file_sb #(.XLEN(32), .NREGS(32), .ZERO_REG(1), .BYPASS(1)) dut_a (
        .clk(clk), .reset(reset),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_be(wr0_be), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_be(wr1_be), .wr1_data(wr1_data),
        .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr),
        .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(o_da[0]), .rd_data_b(o_db[0]), .rd_busy_a(o_ba[0]), .rd_busy_b(o_bb[0]),
        .rd_valid(o_v[0]), .wr_done(o_wd[0])
    );

    reg_file_sb #(.XLEN(32), .NREGS(32), .ZERO_REG(0), .BYPASS(0)) dut_b (
        .clk(clk), .reset(reset),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_be(wr0_be), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_be(wr1_be), .wr1_data(wr1_data),
        .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr),
        .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(o_da[1]), .rd_data_b(o_db[1]), .rd_busy_a(o_ba[1]), .rd_busy_b(o_bb[1]),
        .rd_valid(o_v[1]), .wr_done(o_wd[1])
    );

    function automatic logic [31:0] bmask(input logic [3:0] be);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{be[i]}};
        return m;
    endfunction

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s[%0d] observed=%h expected=%h", tag, k, obs, exp);
        end
    endtask

    task automatic idle();
        reset = 0; wr0_en = 0; wr1_en = 0; sb_set_en = 0; rd_en = 0;
        wr0_addr = 0; wr1_addr = 0; sb_set_addr = 0; rd_addr_a = 0; rd_addr_b = 0;
        wr0_be = 0; wr1_be = 0; wr0_data = 0; wr1_data = 0;
    endtask

    // Model one cycle from the present inputs, clock it, then compare both DUTs.
    task automatic step();
        logic [31:0] nm [32];
        logic [31:0] nb, m0, m1;
        bit on, e0, e1, es;
        for (int k = 0; k < 2; k++) begin
            on = (k == 0);
            e0 = wr0_en && wr0_be != 0 && !(on && wr0_addr == 0);
            e1 = wr1_en && wr1_be != 0 && !(on && wr1_addr == 0);
            es = sb_set_en && !(on && sb_set_addr == 0);
            m0 = bmask(wr0_be);
            m1 = bmask(wr1_be);
            for (int r = 0; r < 32; r++) nm[r] = mem[k][r];
            nb = busy[k];
            if (e0) nm[wr0_addr] = (nm[wr0_addr] & ~m0) | (wr0_data & m0);
            if (e1) nm[wr1_addr] = (nm[wr1_addr] & ~m1) | (wr1_data & m1);
            if (e0) nb[wr0_addr] = 1'b0;
            if (e1) nb[wr1_addr] = 1'b0;
            if (es) nb[sb_set_addr] = 1'b1;
            if (reset) begin
                for (int r = 0; r < 32; r++) mem[k][r] = 0;
                busy[k] = 0;
                e_da[k] = 0; e_db[k] = 0; e_ba[k] = 0; e_bb[k] = 0; e_v[k] = 0; e_wd[k] = 0;
            end else begin
                if (rd_en) begin
                    e_da[k] = (on && rd_addr_a == 0) ? 0 : on ? nm[rd_addr_a] : mem[k][rd_addr_a];
                    e_db[k] = (on && rd_addr_b == 0) ? 0 : on ? nm[rd_addr_b] : mem[k][rd_addr_b];
                    e_ba[k] = (on && rd_addr_a == 0) ? 0 : on ? nb[rd_addr_a] : busy[k][rd_addr_a];
                    e_bb[k] = (on && rd_addr_b == 0) ? 0 : on ? nb[rd_addr_b] : busy[k][rd_addr_b];
                end
                e_v[k] = rd_en;
                e_wd[k] = e0 || e1;
                for (int r = 0; r < 32; r++) mem[k][r] = nm[r];
                busy[k] = nb;
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rd_data_a", k, o_da[k], e_da[k]);
            chk("rd_data_b", k, o_db[k], e_db[k]);
            chk("rd_busy_a", k, 32'(o_ba[k]), 32'(e_ba[k]));
            chk("rd_busy_b", k, 32'(o_bb[k]), 32'(e_bb[k]));
            chk("rd_valid", k, 32'(o_v[k]), 32'(e_v[k]));
            chk("wr_done", k, 32'(o_wd[k]), 32'(e_wd[k]));
        end
    endtask

    initial begin
        idle();
        reset = 1;
        step();
        step();
        // 1: every register reads zero and not busy after reset
        for (int r = 1; r < 32; r++) begin
            idle(); rd_en = 1; rd_addr_a = 5'(r); rd_addr_b = 5'(32 - r);
            step();
            chk("t1_data", 0, o_da[0], 32'h0);
            chk("t1_valid", 0, 32'(o_v[0]), 32'h1);
        end
        idle(); step();
        chk("t1_valid_drop", 0, 32'(o_v[0]), 32'h0);
        // 2: byte-enabled partial overwrite
        idle(); wr0_en = 1; wr0_addr = 5; wr0_be = 4'hF; wr0_data = 32'hDEADBEEF; step();
        chk("t2_done1", 0, 32'(o_wd[0]), 32'h1);
        idle(); wr0_en = 1; wr0_addr = 5; wr0_be = 4'h3; wr0_data = 32'h00001122; step();
        chk("t2_done2", 0, 32'(o_wd[0]), 32'h1);
        idle(); rd_en = 1; rd_addr_a = 5; step();
        chk("t2_r5", 0, o_da[0], 32'hDEAD1122);
        chk("t2_r5", 1, o_da[1], 32'hDEAD1122);
        chk("t2_nodone", 0, 32'(o_wd[0]), 32'h0);
        // 3: same-cycle dual write merge
        idle(); wr0_en = 1; wr0_addr = 7; wr0_be = 4'hF; wr0_data = 32'h11111111;
        wr1_en = 1; wr1_addr = 7; wr1_be = 4'hC; wr1_data = 32'h22222222; step();
        idle(); rd_en = 1; rd_addr_b = 7; step();
        chk("t3_r7", 0, o_db[0], 32'h22221111);
        chk("t3_r7", 1, o_db[1], 32'h22221111);
        // 4: bypass versus pre-write read
        idle(); wr0_en = 1; wr0_addr = 3; wr0_be = 4'hF; wr0_data = 32'h12345678; step();
        idle(); wr0_en = 1; wr0_addr = 3; wr0_be = 4'hF; wr0_data = 32'hA5A5A5A5;
        rd_en = 1; rd_addr_a = 3; step();
        chk("t4_bypass", 0, o_da[0], 32'hA5A5A5A5);
        chk("t4_nobypass", 1, o_da[1], 32'h12345678);
        // 5: scoreboard set/clear priority
        idle(); sb_set_en = 1; sb_set_addr = 9; step();
        idle(); rd_en = 1; rd_addr_a = 9; step();
        chk("t5_busy", 0, 32'(o_ba[0]), 32'h1);
        idle(); wr0_en = 1; wr0_addr = 9; wr0_be = 4'hF; wr0_data = 32'h99; sb_set_en = 1; sb_set_addr = 9;
        rd_en = 1; rd_addr_a = 9; step();
        chk("t5_setwins", 0, 32'(o_ba[0]), 32'h1);
        idle(); wr1_en = 1; wr1_addr = 9; wr1_be = 4'h1; wr1_data = 32'h1; step();
        idle(); rd_en = 1; rd_addr_a = 9; step();
        chk("t5_cleared", 0, 32'(o_ba[0]), 32'h0);
        chk("t5_cleared", 1, 32'(o_ba[1]), 32'h0);
        // 6: R0 hard-wired to zero, and reset mid-write
        idle(); wr0_en = 1; wr0_addr = 0; wr0_be = 4'hF; wr0_data = 32'hFFFFFFFF; sb_set_en = 1; step();
        chk("t6_nodone", 0, 32'(o_wd[0]), 32'h0);
        idle(); rd_en = 1; step();
        chk("t6_r0", 0, o_da[0], 32'h0);
        chk("t6_r0busy", 0, 32'(o_ba[0]), 32'h0);
        chk("t6_r0_plain", 1, o_da[1], 32'hFFFFFFFF);
        idle(); wr0_en = 1; wr0_addr = 10; wr0_be = 4'hF; wr0_data = 32'hCAFEF00D; rd_en = 1; rd_addr_a = 5;
        reset = 1; step();
        chk("t6_rst_data", 0, o_da[0], 32'h0);
        chk("t6_rst_done", 0, 32'(o_wd[0]), 32'h0);
        idle(); rd_en = 1; rd_addr_a = 10; step();
        chk("t6_rst_r10", 0, o_da[0], 32'h0);
        // random traffic on a small address window to force collisions
        for (int n = 0; n < 600; n++) begin
            reset = ($urandom_range(0, 59) == 0);
            wr0_en = ($urandom_range(0, 9) < 6); wr1_en = ($urandom_range(0, 9) < 6);
            wr0_addr = 5'($urandom_range(0, 7)); wr1_addr = 5'($urandom_range(0, 7));
            wr0_be = 4'($urandom_range(0, 15)); wr1_be = 4'($urandom_range(0, 15));
            wr0_data = $urandom; wr1_data = $urandom;
            sb_set_en = ($urandom_range(0, 9) < 4); sb_set_addr = 5'($urandom_range(0, 7));
            rd_en = ($urandom_range(0, 9) < 7);
            rd_addr_a = 5'($urandom_range(0, 7)); rd_addr_b = 5'($urandom_range(0, 31));
            step();
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
